// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: PC stride, default encodings and the
// fetch-state enumeration used by the instruction-fetch queue.
package cpu_pkg;

  localparam int          ADDR_W_DEF    = 32;
  localparam int          INS_W_DEF     = 32;
  localparam int          PC_STEP       = 4;
  localparam logic [31:0] HALT_WORD_DEF = 32'hffff_ffff;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage : cpu_pkg

// File: rtl/ifq_fifo.sv
// Synchronous FIFO with flush; power-of-two depth so pointers wrap naturally.
// The head entry is presented straight from storage (no bypass from push).
module ifq_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: every next-state value is given a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // their inputs from the same pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count gates visibility, so
  // stale contents are never consumed and the array maps onto plain RAM.
  always_ff @(posedge clock) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule : ifq_fifo

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: owns the PC, reads instruction memory each
// cycle and queues {pc, instruction} pairs for ID, with redirect and halt.
module ifetch_queue
  import cpu_pkg::*;
#(
  parameter int               ADDR_W    = ADDR_W_DEF,
  parameter int               INS_W     = INS_W_DEF,
  parameter int               DEPTH     = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [INS_W-1:0] HALT_WORD = INS_W'(HALT_WORD_DEF)
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic [ADDR_W-1:0]          im_addr,
  input  logic [INS_W-1:0]           im_rdata,
  output logic                       id_valid,
  output logic [INS_W-1:0]           id_ins,
  output logic [ADDR_W-1:0]          id_pc,
  input  logic                       id_ready,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       halted,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int WIDTH = ADDR_W + INS_W;

  logic [ADDR_W-1:0] pc_q, pc_d;
  fetch_state_e      state_q, state_d;
  logic              push, pop, empty, full, is_halt;
  logic [WIDTH-1:0]  head;

  assign pop     = id_valid && id_ready;
  assign push    = (state_q == FETCH) && !redirect_valid && (!full || pop);
  assign is_halt = (im_rdata == HALT_WORD);

  // Redirect overrides everything, including a halt word fetched this cycle.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = FETCH;
    end else if (push) begin
      if (is_halt) state_d = HALTED;
      else         pc_d    = pc_q + ADDR_W'(PC_STEP);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      state_q <= FETCH;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  ifq_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .wdata_i ({pc_q, im_rdata}),
    .rdata_o (head),
    .count_o (count),
    .empty_o (empty),
    .full_o  (full)
  );

  assign im_addr  = pc_q;
  assign id_valid = !empty;
  assign id_pc    = head[WIDTH-1 -: ADDR_W];
  assign id_ins   = head[INS_W-1:0];
  assign halted   = (state_q == HALTED);

endmodule : ifetch_queue
